fp_normalize_pack: RTL and testbench
====================================

Name: fp_normalize_pack

Overview:
Back-end partner of the 24-bit sign-magnitude mantissa adder/subtractor in the FP calculator datapath. It takes the adder's raw result (carry-out, 24-bit magnitude, result sign) and the common pre-alignment exponent, normalizes it sequentially, and packs an IEEE-754 single-precision word. It uses the same en/load/ready handshake style as the adder, so the adder's ready and outputs can drive load and the data inputs directly.

Parameters:
MAN_W, 24, mantissa width including the hidden bit; the packed fraction is MAN_W-1 bits.
EXP_W, 8, exponent field width; the result width is 1+EXP_W+MAN_W-1 (32 at defaults).

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
en  in  1  clock enable; when low, all state and outputs hold
load  in  1  start request; sampled only in IDLE or DONE with en=1
sign_in  in  1  result sign from the adder
exp_in  in  EXP_W  biased common exponent (post-alignment)
c_in  in  1  adder carry-out (magnitude overflow bit)
man_in  in  MAN_W  adder magnitude output
result  out  1+EXP_W+MAN_W-1  packed {sign, exp, fraction}
ready  out  1  result valid; held until the next accepted load
busy  out  1  high in CHECK/SHIFT/PACK
zero  out  1  result is +0 from a zero magnitude
overflow  out  1  exponent saturated; result is signed infinity
underflow  out  1  denormal range reached; flushed to signed zero

Behaviour:
- Reset (rst=1 at an edge, has priority over en and load): state=IDLE. result=0, ready=0, busy=0, zero=0, overflow=0, underflow=0. Internal registers are cleared. A reset mid-operation aborts the operation, and no result is produced.
- en=0: the FSM, the internal registers and all outputs hold. load is ignored.
- States: IDLE, CHECK, SHIFT, PACK, DONE.
- IDLE/DONE + load=1: capture sign_in, exp_in (zero-extended to EXP_W+1 bits), c_in and man_in. Clear ready and all flags. Go to CHECK. A load in any other state is ignored (no queueing).
- CHECK (one cycle):
  - c_in=1: set man={1, man[MAN_W-1:1]} (the dropped LSB is truncated; there is no rounding) and exp=exp+1. Go to PACK.
  - else if man=0: go to PACK with zero pending.
  - else if man[MAN_W-1]=1: go to PACK.
  - else if exp<=1: go to PACK with underflow pending.
  - else: go to SHIFT.
- SHIFT (one cycle per bit): man<<=1, exp=exp-1. Leave for PACK as soon as the registered man[MAN_W-1]=1 or exp=1. Unnormalized at exp=1 means underflow pending. At most MAN_W-1 shift cycles.
- PACK (one cycle), checks in this priority order, then goes to DONE with ready=1 and busy=0:
  - zero pending: result=0 (+0 regardless of sign) and zero=1.
  - underflow pending: result={sign, 0...}, underflow=1.
  - exp >= 2^EXP_W-1: result={sign, all-ones exp, 0 fraction}, overflow=1.
  - otherwise: result={sign, exp[EXP_W-1:0], man[MAN_W-2:0]}.
- exp_in=0 with a nonzero, unnormalized man: underflow via the CHECK rule above.
- Latency from the load edge to ready high:
  - normalized, carry or zero case: 3 edges (CHECK, PACK, DONE).
  - n left shifts: 3+n edges.
- result and the flags are stable throughout DONE. busy and ready are never both high.

Test Plan:
- Carry case, 1.5+1.5: c_in=1, man_in=0x800000, exp_in=127, sign_in=0 -> result=0x40400000 (3.0), ready 3 cycles after load, all flags 0.
- Already normalized: c_in=0, man_in=0xC00000, exp_in=127, sign_in=1 -> result=0xBFC00000 in 3 cycles. Then drop en for 5 cycles mid-operation on a repeat load -> ready is delayed by exactly 5 cycles, and the result is identical.
- Maximum shift: man_in=0x000001, exp_in=127 -> 23 SHIFT cycles, result=0x34000000 (exp 104), ready after 26 cycles, busy high for exactly 25 cycles.
- Zero and overflow:
  - man_in=0, sign_in=1 -> result=0x00000000, zero=1.
  - c_in=1, man_in=0x800000, exp_in=254 -> result=0x7F800000, overflow=1.
- Underflow: man_in=0x000100, exp_in=3, sign_in=1 -> two shifts, stop at exp=1, result=0x80000000, underflow=1.
- Control corners:
  - rst asserted on the 5th SHIFT cycle of the 0x000001 case -> next cycle IDLE, all outputs 0, no ready.
  - load pulsed during SHIFT -> ignored.
  - load in DONE -> accepted, ready low on the next cycle.

Source files
------------

// File: rtl/fp_normalize_pack.sv
// fp_normalize_pack: normalizes a raw sign-magnitude adder result one bit per
// cycle and packs it into an IEEE-754 style {sign, exponent, fraction} word.
// Rounding is not performed: bits shifted out on a carry are truncated.
module fp_normalize_pack #(
  parameter int MAN_W = 24,
  parameter int EXP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   load,
  input  logic                   sign_in,
  input  logic [EXP_W-1:0]       exp_in,
  input  logic                   c_in,
  input  logic [MAN_W-1:0]       man_in,
  output logic [EXP_W+MAN_W-1:0] result,
  output logic                   ready,
  output logic                   busy,
  output logic                   zero,
  output logic                   overflow,
  output logic                   underflow
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SHIFT = 3'd2,
    PACK  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // The exponent carries one extra bit so a carry out of 2^EXP_W-1 is visible
  // to the saturation check in PACK.
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  state_t                 r_state;
  logic                   r_sign;
  logic [EXP_W:0]         r_exp;
  logic                   r_c;
  logic [MAN_W-1:0]       r_man;
  logic                   r_zero_pend;
  logic                   r_uf_pend;
  logic [EXP_W+MAN_W-1:0] r_result;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_zero;
  logic                   r_overflow;
  logic                   r_underflow;

  logic [MAN_W-1:0]       w_man_shl;
  logic [EXP_W:0]         w_exp_dec;
  logic [EXP_W:0]         w_exp_inc;
  logic                   w_shift_stop;

  assign w_man_shl    = {r_man[MAN_W-2:0], 1'b0};
  assign w_exp_dec    = r_exp - EXP_ONE;
  assign w_exp_inc    = r_exp + EXP_ONE;
  // SHIFT decides on the value being written this edge, so n shifts take n cycles.
  assign w_shift_stop = w_man_shl[MAN_W-1] || (w_exp_dec == EXP_ONE);

  assign result    = r_result;
  assign ready     = r_ready;
  assign busy      = r_busy;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  // Normalization FSM with its datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_c         <= 1'b0;
      r_man       <= '0;
      r_zero_pend <= 1'b0;
      r_uf_pend   <= 1'b0;
      r_result    <= '0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (en) begin
      case (r_state)
        IDLE, DONE: begin
          if (load) begin
            r_sign      <= sign_in;
            r_exp       <= {1'b0, exp_in};
            r_c         <= c_in;
            r_man       <= man_in;
            r_zero_pend <= 1'b0;
            r_uf_pend   <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_state     <= CHECK;
          end
        end
        CHECK: begin
          if (r_c) begin
            r_man   <= {1'b1, r_man[MAN_W-1:1]};
            r_exp   <= w_exp_inc;
            r_state <= PACK;
          end else if (r_man == '0) begin
            r_zero_pend <= 1'b1;
            r_state     <= PACK;
          end else if (r_man[MAN_W-1]) begin
            r_state <= PACK;
          end else if (r_exp <= EXP_ONE) begin
            r_uf_pend <= 1'b1;
            r_state   <= PACK;
          end else begin
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_man <= w_man_shl;
          r_exp <= w_exp_dec;
          if (w_shift_stop) begin
            // Reaching exp=1 while still unnormalized lands in the denormal range.
            r_uf_pend <= ~w_man_shl[MAN_W-1];
            r_state   <= PACK;
          end
        end
        PACK: begin
          if (r_zero_pend) begin
            r_result <= '0;
            r_zero   <= 1'b1;
          end else if (r_uf_pend) begin
            r_result    <= {r_sign, {(EXP_W+MAN_W-1){1'b0}}};
            r_underflow <= 1'b1;
          end else if (r_exp >= EXP_MAX) begin
            r_result   <= {r_sign, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
            r_overflow <= 1'b1;
          end else begin
            r_result <= {r_sign, r_exp[EXP_W-1:0], r_man[MAN_W-2:0]};
          end
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Scoreboard bench for fp_normalize_pack: stimulus pushes reference results,
// a monitor pops and compares whenever ready rises.
module tb_fp_normalize_pack;

  logic        clk = 1'b0;
  logic        rst, en, load, sign_in, c_in;
  logic [7:0]  exp_in;
  logic [23:0] man_in;
  logic [31:0] result;
  logic        ready, busy, zero, overflow, underflow;

  fp_normalize_pack #(.MAN_W(24), .EXP_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .sign_in(sign_in),
    .exp_in(exp_in), .c_in(c_in), .man_in(man_in), .result(result),
    .ready(ready), .busy(busy), .zero(zero), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    bit          zf, ovf, uff;
    int          lat;
    int          load_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: value-level normalization of the raw adder result.
  function automatic exp_t model(input bit s, input int e, input bit c, input int m);
    exp_t r;
    int   n = 0;
    int   msb, lz;
    logic [7:0] ef;
    logic [22:0] ff;
    r.zf = 0; r.ovf = 0; r.uff = 0; r.load_cyc = 0;
    if (c) begin
      m = (m >> 1) | (1 << 23);
      e = e + 1;
    end else if (m == 0) begin
      r.zf = 1;
    end else begin
      msb = 0;
      for (int b = 0; b < 24; b++) if ((m >> b) & 1) msb = b;
      lz = 23 - msb;
      if (lz > 0) begin
        if (e <= 1) r.uff = 1;
        else begin
          n = (lz < e - 1) ? lz : e - 1;
          m = m << n;
          e = e - n;
          if (n < lz) r.uff = 1;
        end
      end
    end
    ef = e[7:0];
    ff = m[22:0];
    if (r.zf) r.res = 32'h0;
    else if (r.uff) r.res = {s, 31'h0};
    else if (e >= 255) begin r.res = {s, 8'hFF, 23'h0}; r.ovf = 1; end
    else r.res = {s, ef, ff};
    r.lat = 3 + n;
    return r;
  endfunction

  // Monitor: compares each ready rising edge against the oldest expectation.
  int   busy_cnt = 0;
  bit   prev_ready = 0;
  int   n_done = 0;
  exp_t mon_it;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt   = 0;
        prev_ready = 0;
      end else begin
        if (busy) busy_cnt++;
        if (ready && busy) chk("busy_and_ready", 1, 0);
        if (ready && !prev_ready) begin
          if (sb.size() == 0) chk("unexpected_ready", 1, 0);
          else begin
            mon_it = sb.pop_front();
            chk($sformatf("result#%0d", n_done), result, mon_it.res);
            chk($sformatf("flags#%0d", n_done), {zero, overflow, underflow},
                {mon_it.zf, mon_it.ovf, mon_it.uff});
            chk($sformatf("latency#%0d", n_done), cyc - mon_it.load_cyc + 1, mon_it.lat);
            chk($sformatf("busy_cycles#%0d", n_done), busy_cnt, mon_it.lat - 1);
            n_done++;
          end
          busy_cnt = 0;
        end
        prev_ready = ready;
      end
    end
  end

  // One transaction; starts and ends just after a rising edge.
  task automatic do_txn(input bit s, input int e, input bit c, input int m,
                        input int stall, input bit glitch);
    exp_t it;
    it = model(s, e, c, m);
    it.lat = it.lat + stall;
    load = 1; sign_in = s; exp_in = e[7:0]; c_in = c; man_in = m[23:0];
    it.load_cyc = cyc + 1;
    sb.push_back(it);
    @(posedge clk); #1;
    load = 0;
    chk("ready_low_after_load", ready, 0);
    if (stall > 0) begin
      en = 0;
      repeat (stall) begin @(posedge clk); #1; end
      en = 1;
    end
    if (glitch) begin
      repeat (3) begin @(posedge clk); #1; end
      load = 1; man_in = 24'hABCDEF; c_in = 1; exp_in = 8'd9;
      @(posedge clk); #1;
      load = 0;
    end
    for (int k = 0; k < 300 && !ready; k++) begin @(posedge clk); #1; end
    if (!ready) begin
      chk("ready_timeout", 0, 1);
      if (sb.size() != 0) void'(sb.pop_front());
      rst = 1; @(posedge clk); #1; rst = 0;
    end
  endtask

  task automatic reset_mid_shift();
    int seen = 0;
    load = 1; sign_in = 0; exp_in = 8'd127; c_in = 0; man_in = 24'h000001;
    @(posedge clk); #1;
    load = 0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_result", result, 0);
    chk("rst_flags", {ready, busy, zero, overflow, underflow}, 0);
    repeat (40) begin
      @(posedge clk); #1;
      if (ready || busy) seen++;
    end
    chk("no_activity_after_rst", seen, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e, c, m, st;
    rst = 1; en = 1; load = 0; sign_in = 0; exp_in = 0; c_in = 0; man_in = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", result, 0);
    chk("reset_flags", {ready, busy, zero, overflow, underflow}, 0);
    rst = 0;
    @(posedge clk); #1;

    do_txn(0, 127, 1, 'h800000, 0, 0);   // 1.5+1.5 carry
    do_txn(1, 127, 0, 'hC00000, 0, 0);   // already normalized
    do_txn(1, 127, 0, 'hC00000, 5, 0);   // same, with en low for 5 cycles
    do_txn(0, 127, 0, 'h000001, 0, 0);   // maximum shift
    do_txn(1, 127, 0, 'h000000, 0, 0);   // zero magnitude
    do_txn(0, 254, 1, 'h800000, 0, 0);   // overflow to infinity
    do_txn(1, 3,   0, 'h000100, 0, 0);   // underflow after two shifts
    do_txn(0, 0,   0, 'h400000, 0, 0);   // exp 0, unnormalized
    do_txn(1, 1,   0, 'h7FFFFF, 0, 0);   // exp 1, unnormalized
    do_txn(0, 24,  0, 'h000001, 0, 0);   // normalizes exactly at exp 1
    do_txn(1, 255, 1, 'hFFFFFF, 0, 0);   // carry past exponent max
    do_txn(0, 127, 0, 'h000001, 0, 1);   // load pulsed during SHIFT
    reset_mid_shift();

    for (int i = 0; i < 40; i++) begin
      s = $urandom_range(0, 1);
      c = ($urandom_range(0, 3) == 0) ? 1 : 0;
      m = int'(($urandom & 32'h00FFFFFF) >> $urandom_range(0, 24));
      case ($urandom_range(0, 3))
        0: e = $urandom_range(0, 4);
        1: e = $urandom_range(250, 255);
        default: e = $urandom_range(0, 255);
      endcase
      st = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      do_txn(s[0], e, c[0], m, st, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
